// File: rtl/regfile_ctrl_pkg.sv
// Shared types and encodings for the regfile/datapath sequencer.
// Optional illegal-trap state is used only when REGFILE_CTRL_ILLEGAL_EN is defined.
package regfile_ctrl_pkg;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] MOV_OP_IMM = 2'b10;
   localparam logic [1:0] MOV_OP_REG = 2'b00;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b01;

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_DECODE  = 3'd1,
      S_GETA    = 3'd2,
      S_GETB    = 3'd3,
      S_ALU     = 3'd4,
      S_WREG    = 3'd5,
      S_WIMM    = 3'd6,
      S_ILLEGAL = 3'd7
   } state_e;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake plus regfile/datapath control bundle.
// The illegal flag exists only when REGFILE_CTRL_ILLEGAL_EN is defined.
interface regfile_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
);
   logic              s;
   logic [DATA_W-1:0] in;
   logic              w;
   logic [REG_W-1:0]  readnum;
   logic [REG_W-1:0]  writenum;
   logic              write;
   logic              loada;
   logic              loadb;
   logic              loadc;
   logic              loads;
   logic              asel;
   logic              bsel;
   logic [1:0]        vsel;
   logic [1:0]        alu_op;
   logic [1:0]        shift;
   logic [DATA_W-1:0] sximm8;
`ifdef REGFILE_CTRL_ILLEGAL_EN
   logic              illegal;
`endif

   modport master (
`ifdef REGFILE_CTRL_ILLEGAL_EN
      input  illegal,
`endif
      output s, in,
      input  w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, alu_op, shift, sximm8
   );

   modport slave (
`ifdef REGFILE_CTRL_ILLEGAL_EN
      output illegal,
`endif
      input  s, in,
      output w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, alu_op, shift, sximm8
   );

endinterface

// File: rtl/regfile_ctrl_dec.sv
// Combinational field extraction, sign extension and instruction-class decode of IR.
module regfile_ctrl_dec
   import regfile_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic [DATA_W-1:0] ir,
   output logic [1:0]        op,
   output logic [1:0]        sh,
   output logic [REG_W-1:0]  rn,
   output logic [REG_W-1:0]  rd,
   output logic [REG_W-1:0]  rm,
   output logic [DATA_W-1:0] sximm8,
   output logic              is_mov_imm,
   output logic              is_mov_reg,
   output logic              is_alu,
   output logic              is_cmp,
   output logic              is_mvn
);

   logic [2:0] opcode;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm8 = sext8(ir[7:0]);

   assign is_mov_imm = (opcode == OPC_MOV) && (op == MOV_OP_IMM);
   assign is_mov_reg = (opcode == OPC_MOV) && (op == MOV_OP_REG);
   assign is_alu     = (opcode == OPC_ALU);
   assign is_cmp     = is_alu && (op == ALU_CMP);
   assign is_mvn     = is_alu && (op == ALU_MVN);

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle Moore sequencer driving the 8x16 regfile and A/B/C datapath.
// Define REGFILE_CTRL_ILLEGAL_EN to trap undefined encodings in S_ILLEGAL.
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   regfile_ctrl_if.slave  bus
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;

   logic [1:0]        op, sh;
   logic [REG_W-1:0]  rn, rd, rm;
   logic [DATA_W-1:0] sximm8;
   logic              is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

   logic              w_s, write_s, loada_s, loadb_s, loadc_s, loads_s, asel_s;
   logic [REG_W-1:0]  readnum_s, writenum_s;
   logic [1:0]        vsel_s, alu_op_s, shift_s;
`ifdef REGFILE_CTRL_ILLEGAL_EN
   logic              illegal_s;
`endif

   regfile_ctrl_dec #(.DATA_W(DATA_W), .REG_W(REG_W)) u_dec (
      .ir         (ir_q),
      .op         (op),
      .sh         (sh),
      .rn         (rn),
      .rd         (rd),
      .rm         (rm),
      .sximm8     (sximm8),
      .is_mov_imm (is_mov_imm),
      .is_mov_reg (is_mov_reg),
      .is_alu     (is_alu),
      .is_cmp     (is_cmp),
      .is_mvn     (is_mvn)
   );

   // State register and instruction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_WAIT;
         ir_q    <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next state; IR only loads on an accepted start
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_WAIT: begin
            if (bus.s) begin
               ir_d    = bus.in;
               state_d = S_DECODE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DECODE: begin
            if (is_mov_imm) begin
               state_d = S_WIMM;
            end else if (is_mov_reg) begin
               state_d = S_GETB;
            end else if (is_alu) begin
               case (op)
                  ALU_ADD, ALU_AND, ALU_CMP: state_d = S_GETA;
                  ALU_MVN:                   state_d = S_GETB;
                  default:                   state_d = S_WAIT;
               endcase
            end else begin
`ifdef REGFILE_CTRL_ILLEGAL_EN
               state_d = S_ILLEGAL;
`else
               state_d = S_WAIT;
`endif
            end
         end
         S_GETA: state_d = S_GETB;
         S_GETB: state_d = S_ALU;
         S_ALU: begin
            if (is_cmp) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_WREG;
            end
         end
         S_WREG: state_d = S_WAIT;
         S_WIMM: state_d = S_WAIT;
`ifdef REGFILE_CTRL_ILLEGAL_EN
         S_ILLEGAL: state_d = S_ILLEGAL;
`else
         S_ILLEGAL: state_d = S_WAIT;
`endif
         default: state_d = S_WAIT;
      endcase
   end

   // Moore output decode from state and IR
   always_comb begin
      w_s        = 1'b0;
      readnum_s  = {REG_W{1'b0}};
      writenum_s = {REG_W{1'b0}};
      write_s    = 1'b0;
      loada_s    = 1'b0;
      loadb_s    = 1'b0;
      loadc_s    = 1'b0;
      loads_s    = 1'b0;
      asel_s     = 1'b0;
      vsel_s     = VSEL_C;
`ifdef REGFILE_CTRL_ILLEGAL_EN
      illegal_s  = 1'b0;
`endif
      if (is_mov_imm) begin
         shift_s  = 2'b00;
         alu_op_s = 2'b00;
      end else begin
         shift_s  = sh;
         alu_op_s = op;
      end
      case (state_q)
         S_WAIT: w_s = 1'b1;
         S_GETA: begin
            readnum_s = rn;
            loada_s   = 1'b1;
         end
         S_GETB: begin
            readnum_s = rm;
            loadb_s   = 1'b1;
         end
         S_ALU: begin
            asel_s = is_mov_reg | is_mvn;
            if (is_cmp) begin
               loads_s = 1'b1;
            end else begin
               loadc_s = 1'b1;
            end
         end
         S_WREG: begin
            writenum_s = rd;
            vsel_s     = VSEL_C;
            write_s    = 1'b1;
         end
         S_WIMM: begin
            writenum_s = rn;
            vsel_s     = VSEL_IMM;
            write_s    = 1'b1;
         end
         S_ILLEGAL: begin
`ifdef REGFILE_CTRL_ILLEGAL_EN
            illegal_s = 1'b1;
`endif
         end
         default: w_s = 1'b0;
      endcase
   end

   assign bus.w        = w_s;
   assign bus.readnum  = readnum_s;
   assign bus.writenum = writenum_s;
   assign bus.write    = write_s;
   assign bus.loada    = loada_s;
   assign bus.loadb    = loadb_s;
   assign bus.loadc    = loadc_s;
   assign bus.loads    = loads_s;
   assign bus.asel     = asel_s;
   assign bus.bsel     = 1'b0;
   assign bus.vsel     = vsel_s;
   assign bus.alu_op   = alu_op_s;
   assign bus.shift    = shift_s;
   assign bus.sximm8   = sximm8;
`ifdef REGFILE_CTRL_ILLEGAL_EN
   assign bus.illegal  = illegal_s;
`endif

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Multi-cycle Moore controller that sequences the 8x16 register file and the A/B/C datapath for the simple RISC instruction set.
- Accepts one 16-bit instruction per start handshake and decodes it.
- Steps the datapath through register reads, the ALU operation and write-back.
- Sits between the instruction source (testbench or future fetch unit) and the regfile/datapath.

Parameters:
- DATA_W, 16, instruction and immediate width.
- REG_W, 3, register-number width (8 registers).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s  in  1  start; sampled only in S_WAIT
- in  in  DATA_W  instruction; latched when s=1 in S_WAIT
- w  out  1  1 = idle, ready for s
- readnum  out  REG_W  regfile read select
- writenum  out  REG_W  regfile write select
- write  out  1  regfile write enable
- loada, loadb, loadc, loads  out  1 each  datapath register load enables
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand is sximm5 (reserved; always 0 this revision)
- vsel  out  2  write-back source: 00 = C, 01 = sximm8, others reserved
- alu_op  out  2  ALU operation
- shift  out  2  shifter control
- sximm8  out  DATA_W  sign-extended in[7:0]
- illegal  out  1  present only with REGFILE_CTRL_ILLEGAL_EN

Behaviour:
- Clocking and reset
  - One clock domain.
  - rst_n low asynchronously forces state S_WAIT and clears the instruction register (IR) to 0.
  - Mid-instruction reset aborts with no write.
- Instruction fields (from IR)
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Outputs
  - All outputs are Moore, decoded from state plus IR.
  - Default 0 / 2'b00 in every state except where listed.
  - During and after reset: w=1, all enables 0.
  - shift = sh; alu_op = op, except shift = 00 and alu_op = 00 for MOV-immediate.
  - sximm8 is always driven from IR.
- States
  - S_WAIT: w=1. If s=1, latch IR and go to S_DECODE; otherwise hold.
  - S_DECODE:
    - MOV imm (110/10) -> S_WIMM
    - MOV reg (110/00) -> S_GETB
    - ALU (101/xx): MVN (op=11) -> S_GETB; all other ops -> S_GETA
    - Anything else -> S_WAIT
  - S_GETA: readnum=Rn, loada=1 -> S_GETB.
  - S_GETB: readnum=Rm, loadb=1 -> S_ALU.
  - S_ALU: asel=1 for MOV reg and MVN.
    - CMP: loads=1 -> S_WAIT.
    - Otherwise: loadc=1 -> S_WREG.
  - S_WREG: writenum=Rd, vsel=00, write=1 -> S_WAIT.
  - S_WIMM: writenum=Rn, vsel=01, write=1 -> S_WAIT.
- Latency (s high to w high again)
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - ADD / AND: 6 cycles.
  - CMP: 5 cycles.
- Boundary conditions
  - s outside S_WAIT is ignored, and in does not change IR.
  - s held high re-triggers on the first S_WAIT cycle, giving back-to-back instructions.
  - write is never asserted in the same cycle as any load*.
  - Rd = Rn = Rm is legal; reads precede the write.

Optional Feature:
- Macro: REGFILE_CTRL_ILLEGAL_EN.
- When defined:
  - Undefined opcode/op in S_DECODE goes to S_ILLEGAL.
  - S_ILLEGAL holds with illegal=1 and w=0 until rst_n.
  - The illegal port exists.
- When undefined:
  - No illegal port.
  - Undefined encodings return to S_WAIT with no side effects.

Decomposition:
- Package regfile_ctrl_pkg:
  - state enum;
  - OPC_MOV=3'b110, OPC_ALU=3'b101;
  - ALU op codes ADD=00, CMP=01, AND=10, MVN=11;
  - VSEL_C=2'b00, VSEL_IMM=2'b01.
- Sub-module regfile_ctrl_dec: combinational field extraction, sign extension and instruction-class decode from IR.
- FSM and output decode stay in regfile_ctrl.

Test Plan:
- Reset: rst_n low mid-S_GETA -> next cycle w=1, write=0; IR=0.
- MOV R3,#-5 (in=16'hD3FB), s pulse -> S_WIMM: writenum=3, vsel=01, sximm8=16'hFFFB, write=1; w=1 three cycles after s.
- ADD R2,R1,R0 LSL1 (in=16'hA148):
  - GETA: readnum=1, loada=1.
  - GETB: readnum=0, loadb=1.
  - ALU: loadc=1, shift=01, alu_op=00.
  - WREG: writenum=2, write=1.
- CMP R1,R0 (in=16'hA900) -> loads=1 in S_ALU; write never asserted; returns to S_WAIT after 5 cycles.
- MVN R7,R4 (in=16'hB8E4) -> no S_GETA; asel=1 in S_ALU; writenum=7.
- s toggled during a busy cycle with a different in -> ignored; IR unchanged.
- Illegal in=16'h0000:
  - with REGFILE_CTRL_ILLEGAL_EN: illegal=1 held until reset.
  - without it: w=1 two cycles after s.
